// File: rtl/uart_if_pkg.sv
// Shared definitions for the UART receive-drain logic.
//  - Bit positions inside the UART status byte.
//  - Encoding of the read-sequence state machine.
package uart_if_pkg;

   // UART status byte bit positions
   localparam int unsigned ST_BUF_FULL = 0;
   localparam int unsigned ST_RX_RUN   = 5;
   localparam int unsigned ST_TX_PEND  = 6;
   localparam int unsigned ST_TX_RUN   = 7;

   // Read sequence: wait for a byte, strobe the data select, capture, wait for the flag to clear
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STROBE  = 2'd1,
      CAPT    = 2'd2,
      WAITCLR = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with a registered head byte.
// Ports:
//  clk, nReset  clock and asynchronous active-low reset
//  push         write pushData (ignored while full or during flush)
//  pushData     byte to store
//  pop          consume the head byte (ignored while empty or during flush)
//  flush        synchronous clear of all entries
//  headData     registered copy of the head entry
//  level        stored entries, 0..DEPTH
//  empty        no head byte presented to the consumer
//  full         level == DEPTH
module uart_byte_fifo
   import uart_if_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned LEVEL_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   nReset,
   input  logic                   push,
   input  logic [7:0]             pushData,
   input  logic                   pop,
   input  logic                   flush,
   output logic [7:0]             headData,
   output logic [LEVEL_WIDTH-1:0] level,
   output logic                   empty,
   output logic                   full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]             mem [DEPTH];
   logic [LEVEL_WIDTH-1:0] wptr;
   logic [LEVEL_WIDTH-1:0] rptr;
   logic                   head_valid;
   logic                   do_push;
   logic                   do_pop;
   logic [AW-1:0]          rd_idx;
   logic [AW-1:0]          nxt_idx;

   // Pointers carry one extra bit so that full and empty differ in level
   assign level   = wptr - rptr;
   assign full    = (level == LEVEL_WIDTH'(DEPTH));
   assign empty   = !head_valid;
   assign do_push = push && !flush && !full;
   assign do_pop  = pop && head_valid && !flush;
   assign rd_idx  = rptr[AW-1:0];
   assign nxt_idx = rd_idx + AW'(1);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr[AW-1:0]] <= pushData;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + LEVEL_WIDTH'(1);
         if (do_pop)  rptr <= rptr + LEVEL_WIDTH'(1);
      end
   end

   // The head register only looks at entries stored before this edge, so a freshly
   // pushed byte becomes visible one cycle after its push (no fall-through).
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         head_valid <= 1'b0;
         headData   <= '0;
      end else if (flush) begin
         head_valid <= 1'b0;
      end else if (do_pop) begin
         head_valid <= (level > LEVEL_WIDTH'(1));
         headData   <= mem[nxt_idx];
      end else if (!head_valid && (level != '0)) begin
         head_valid <= 1'b1;
         headData   <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/uart_rx_drain_fifo.sv
// Drains received bytes from the UART register interface into a local FIFO and
// presents them on a valid/ready stream.
// Ports:
//  clk, nReset     clock and asynchronous active-low reset
//  uartStatusOut   UART status byte (buffer full, rx run, tx pending, tx run)
//  uartDataOut     UART received byte
//  uartNCsDataOut  active-low one-cycle read strobe to the UART data register
//  uartNCsStatus   active-low status select, low whenever out of reset
//  rxData          head byte of the FIFO
//  rxValid         a head byte is presented
//  rxReady         consumer accepts rxData on a clk edge with rxValid
//  rxLevel         stored bytes, 0..DEPTH
//  flush           synchronous FIFO clear
module uart_rx_drain_fifo
   import uart_if_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned LEVEL_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   nReset,
   input  logic [7:0]             uartStatusOut,
   input  logic [7:0]             uartDataOut,
   output logic                   uartNCsDataOut,
   output logic                   uartNCsStatus,
   output logic [7:0]             rxData,
   output logic                   rxValid,
   input  logic                   rxReady,
   output logic [LEVEL_WIDTH-1:0] rxLevel,
   input  logic                   flush
);

   logic [7:0] statusQ;
   logic       ncs_status_q;
   rx_state_e  state_q;
   rx_state_e  state_d;
   logic       push;
   logic       pop;
   logic       fifo_empty;
   logic       fifo_full;
   logic       unused_status;

   // rxRun and the reserved status bits do not gate anything
   assign unused_status = ^statusQ[ST_TX_PEND-1:ST_BUF_FULL+1];

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         statusQ      <= '0;
         ncs_status_q <= 1'b1;
      end else begin
         statusQ      <= uartStatusOut;
         ncs_status_q <= 1'b0;
      end
   end

   assign uartNCsStatus = ncs_status_q;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (statusQ[ST_BUF_FULL] && !statusQ[ST_TX_PEND] && !statusQ[ST_TX_RUN] &&
                !fifo_full) begin
               state_d = STROBE;
            end
         end
         STROBE:  state_d = CAPT;
         CAPT:    state_d = WAITCLR;
         // Hold until the UART drops its flag so the same byte is never read twice
         WAITCLR: if (!statusQ[ST_BUF_FULL]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      uartNCsDataOut = 1'b1;
      push           = 1'b0;
      if (state_q == STROBE) uartNCsDataOut = 1'b0;
      if (state_q == CAPT)   push = !flush;
   end

   assign pop     = rxReady && !fifo_empty && !flush;
   assign rxValid = !fifo_empty;

   uart_byte_fifo #(
      .DEPTH       (DEPTH),
      .LEVEL_WIDTH (LEVEL_WIDTH)
   ) u_fifo (
      .clk      (clk),
      .nReset   (nReset),
      .push     (push),
      .pushData (uartDataOut),
      .pop      (pop),
      .flush    (flush),
      .headData (rxData),
      .level    (rxLevel),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

endmodule

// File: tb/tb_uart_rx_drain_fifo.sv
// Self-checking bench for uart_rx_drain_fifo: directed scenarios plus a randomized UART
// emulation, all compared every cycle against a queue-based behavioural model.
module tb_uart_rx_drain_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = 3;

   logic          clk = 1'b0;
   logic          nReset;
   logic [7:0]    status;
   logic [7:0]    data;
   logic          uartNCsDataOut;
   logic          uartNCsStatus;
   logic [7:0]    rxData;
   logic          rxValid;
   logic          rxReady;
   logic [LW-1:0] rxLevel;
   logic          flush;

   always #5 clk = ~clk;

   uart_rx_drain_fifo #(
      .DEPTH       (DEPTH),
      .LEVEL_WIDTH (LW)
   ) dut (
      .clk            (clk),
      .nReset         (nReset),
      .uartStatusOut  (status),
      .uartDataOut    (data),
      .uartNCsDataOut (uartNCsDataOut),
      .uartNCsStatus  (uartNCsStatus),
      .rxData         (rxData),
      .rxValid        (rxValid),
      .rxReady        (rxReady),
      .rxLevel        (rxLevel),
      .flush          (flush)
   );

   int checks   = 0;
   int failures = 0;
   int strobes  = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_q: bytes held; m_valid: consumer sees a byte; m_rd: cycles into a read (0 = none,
   // 1 = strobe cycle, 2 = capture cycle, 3 = waiting for flag drop); m_st: status one clk late.
   logic [7:0] m_q[$];
   bit         m_valid = 0;
   int         m_rd    = 0;
   logic [7:0] m_st    = '0;
   bit         m_live  = 0;

   task automatic model_reset();
      m_q.delete();
      m_valid = 0;
      m_rd    = 0;
      m_st    = '0;
      m_live  = 0;
   endtask

   task automatic model_step();
      int old_size;
      bit go;
      old_size = m_q.size();
      m_live   = 1;
      go = m_st[0] && !m_st[6] && !m_st[7] && (old_size < DEPTH);
      if (flush) begin
         m_q.delete();
         m_valid = 0;
      end else begin
         if (m_valid && rxReady) begin
            void'(m_q.pop_front());
            m_valid = (old_size >= 2);
         end else if (!m_valid && old_size > 0) begin
            m_valid = 1;
         end
         if (m_rd == 2) m_q.push_back(data);
      end
      if (m_rd == 0)      m_rd = go ? 1 : 0;
      else if (m_rd < 3)  m_rd = m_rd + 1;
      else if (!m_st[0])  m_rd = 0;
      m_st = status;
   endtask

   initial begin : model_proc
      forever begin
         @(posedge clk or negedge nReset);
         if (!nReset) model_reset();
         else model_step();
      end
   end

   initial begin : compare_proc
      forever begin
         @(negedge clk);
         chk("ncs_data", int'(uartNCsDataOut), (m_rd == 1) ? 0 : 1);
         chk("ncs_status", int'(uartNCsStatus), m_live ? 0 : 1);
         chk("rx_valid", int'(rxValid), int'(m_valid));
         chk("rx_level", int'(rxLevel), m_q.size());
         if (m_valid) chk("rx_data", int'(rxData), int'(m_q[0]));
      end
   end

   always @(negedge clk) if (uartNCsDataOut === 1'b0) strobes++;

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_strobe(input int budget, output bit seen);
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!uartNCsDataOut) begin
            seen = 1;
            break;
         end
      end
   endtask

   // Present a byte, wait for its strobe, optionally flush in the capture cycle,
   // and drop bufferFull two clk after the strobe.
   task automatic offer(input logic [7:0] b, input bit do_flush);
      bit seen;
      @(negedge clk);
      data      = b;
      status[0] = 1'b1;
      wait_strobe(12, seen);
      chk("strobe_seen", int'(seen), 1);
      @(negedge clk);
      if (do_flush) flush = 1'b1;
      @(negedge clk);
      flush     = 1'b0;
      status[0] = 1'b0;
   endtask

   initial begin : stim
      logic [7:0] got[$];
      int         s0;
      bit         seen;
      bit         pend;
      int         clr;
      int         gap;
      logic [1:0] tx;

      nReset  = 1'b0;
      status  = '0;
      data    = '0;
      rxReady = 1'b0;
      flush   = 1'b0;

      // 1. reset values, then release
      tick(3);
      chk("rst_ncs_data", int'(uartNCsDataOut), 1);
      chk("rst_ncs_status", int'(uartNCsStatus), 1);
      chk("rst_rx_valid", int'(rxValid), 0);
      chk("rst_rx_level", int'(rxLevel), 0);
      chk("rst_rx_data", int'(rxData), 0);
      #2 nReset = 1'b1;
      tick(2);
      chk("run_ncs_status", int'(uartNCsStatus), 0);
      chk("run_ncs_data", int'(uartNCsDataOut), 1);

      // 2. single byte
      s0 = strobes;
      offer(8'h3B, 0);
      tick(3);
      chk("t2_strobes", strobes - s0, 1);
      chk("t2_valid", int'(rxValid), 1);
      chk("t2_data", int'(rxData), 8'h3B);
      chk("t2_level", int'(rxLevel), 1);
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
      tick(1);
      chk("t2_level_after_pop", int'(rxLevel), 0);

      // 3. burst under backpressure, then drain in order
      offer(8'h97, 0);
      offer(8'h12, 0);
      offer(8'h34, 0);
      tick(2);
      chk("t3_level", int'(rxLevel), 3);
      rxReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (rxValid) got.push_back(rxData);
         @(negedge clk);
      end
      rxReady = 1'b0;
      chk("t3_pop_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("t3_pop0", int'(got[0]), 8'h97);
         chk("t3_pop1", int'(got[1]), 8'h12);
         chk("t3_pop2", int'(got[2]), 8'h34);
      end
      chk("t3_level_end", int'(rxLevel), 0);

      // 4. full FIFO holds the fifth byte in the UART
      offer(8'hA1, 0);
      offer(8'hB2, 0);
      offer(8'hC3, 0);
      offer(8'hD4, 0);
      tick(2);
      chk("t4_level_full", int'(rxLevel), 4);
      s0        = strobes;
      data      = 8'h5E;
      status[0] = 1'b1;
      tick(20);
      chk("t4_no_strobe", strobes - s0, 0);
      chk("t4_level_held", int'(rxLevel), 4);
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
      wait_strobe(12, seen);
      chk("t4_fifth_strobe", int'(seen), 1);
      tick(2);
      status[0] = 1'b0;
      tick(3);
      chk("t4_level_refill", int'(rxLevel), 4);
      rxReady = 1'b1;
      tick(10);
      rxReady = 1'b0;
      chk("t4_level_drained", int'(rxLevel), 0);

      // 5. TX activity gates the read
      s0     = strobes;
      data   = 8'h66;
      status = 8'h81;
      tick(20);
      chk("t5_txrun_block", strobes - s0, 0);
      status = 8'h41;
      tick(20);
      chk("t5_txpend_block", strobes - s0, 0);
      status = 8'h01;
      wait_strobe(3, seen);
      chk("t5_strobe_fast", int'(seen), 1);
      tick(2);
      status = 8'h00;
      tick(3);
      chk("t5_level", int'(rxLevel), 1);

      // 6a. flush during capture discards the byte and the stored one
      offer(8'h77, 1);
      tick(2);
      chk("t6_flush_level", int'(rxLevel), 0);
      chk("t6_flush_valid", int'(rxValid), 0);

      // 6b. reset while waiting for the flag to clear
      @(negedge clk);
      data      = 8'h88;
      status[0] = 1'b1;
      wait_strobe(12, seen);
      chk("t6_strobe_seen", int'(seen), 1);
      tick(2);
      #2;
      nReset    = 1'b0;
      status[0] = 1'b0;
      @(negedge clk);
      chk("t6_rst_level", int'(rxLevel), 0);
      chk("t6_rst_ncs_status", int'(uartNCsStatus), 1);
      #2 nReset = 1'b1;
      tick(4);
      chk("t6_post_level", int'(rxLevel), 0);
      chk("t6_post_valid", int'(rxValid), 0);
      chk("t6_post_ncs_data", int'(uartNCsDataOut), 1);

      // Randomized UART emulation
      pend = 0;
      clr  = -1;
      gap  = 0;
      tx   = 2'b00;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         rxReady = ($urandom_range(0, 99) < ((c < 1000) ? 60 : 20));
         flush   = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 9) == 0) begin
            tx = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         end
         if (pend) begin
            if (clr > 0) begin
               clr--;
               if (clr == 0) begin
                  pend = 0;
                  clr  = -1;
                  gap  = $urandom_range(0, 5);
               end
            end else if (!uartNCsDataOut) begin
               clr = $urandom_range(1, 3);
            end
         end else if (gap > 0) begin
            gap--;
         end else begin
            pend = 1;
            data = 8'($urandom);
         end
         status = {tx, 5'($urandom_range(0, 31)), pend};
      end

      @(negedge clk);
      status  = '0;
      flush   = 1'b0;
      rxReady = 1'b1;
      tick(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
